rr_grant_arbiter: RTL

Round-robin arbiter that shares one display/resource slot among N requesters (board switches or internal clients) and keeps each grant until the requester releases it. Registers the granted index and its BCD tens/ones digits so they can drive the existing multiplexed seven-segment driver directly. Replaces the fixed-priority, stateless selection path with fair, sequenced ownership.

---
 rtl/arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/rr_grant_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package arb_pkg;

    // Arbiter sequencing: wait for a request, own the slot, one dead cycle.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_e;

    // One decimal digit for the seven-segment driver.
    typedef logic [3:0] bcd_t;

    // Width of a counter that must be able to hold the value max_hold.
    function automatic int hold_cnt_width(input int max_hold);
        return $clog2(max_hold + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrapping first-one search: finds the first set request bit scanning from
// ptr upward and wrapping to 0. Purely combinational.
module rr_pick #(
    parameter int N    = 16,
    parameter int OUTW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [OUTW-1:0] ptr,
    output logic            found,
    output logic [OUTW-1:0] idx
);

    logic [2*N-1:0] req_dbl;
    logic [2*N-1:0] req_cand;

    // Doubling the vector turns the wrapping scan into a linear one: bits
    // below ptr are masked off in the low copy and reappear in the high copy.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise the tool infers a latch.
        found    = 1'b0;
        idx      = '0;
        req_dbl  = {req, req};
        req_cand = req_dbl & ~(((2*N)'(1) << ptr) - (2*N)'(1));
        // Scan downward so the lowest set candidate is the one left standing.
        for (int j = 2*N-1; j >= 0; j--) begin
            if (req_cand[j]) begin
                found = 1'b1;
                idx   = (j >= N) ? OUTW'(j - N) : OUTW'(j);
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter: one owner at a time, grant held until the owner drops
// its request, one dead cycle between owners, registered BCD of the index.
// Optional feature: define ARB_TIMEOUT_EN to force-release a grant that has
// been held for MAX_HOLD cycles.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 16,
    parameter int OUTW     = $clog2(N),
    parameter int MAX_HOLD = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [OUTW-1:0] gnt_idx,
    output bcd_t            tens,
    output bcd_t            ones
);

    // Reject an unusable hold limit at elaboration.
    if (MAX_HOLD < 2) begin : g_max_hold_check
        $error("rr_grant_arbiter: MAX_HOLD must be at least 2");
    end

    arb_state_e      state_q,     state_d;
    logic [OUTW-1:0] ptr_q,       ptr_d;
    logic [N-1:0]    gnt_q,       gnt_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic [OUTW-1:0] gnt_idx_q,   gnt_idx_d;
    bcd_t            tens_q,      tens_d;
    bcd_t            ones_q,      ones_d;

    logic            pick_found;
    logic [OUTW-1:0] pick_idx;
    logic            timeout_hit;

    rr_pick #(
        .N    (N),
        .OUTW (OUTW)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = hold_cnt_width(MAX_HOLD);

    logic [CNT_W-1:0] hold_q, hold_d;

    assign timeout_hit = (hold_q == CNT_W'(MAX_HOLD - 1));

    // Hold counter: cleared when a grant starts, counts every GRANT cycle.
    always_comb begin
        hold_d = hold_q;
        if (state_q == IDLE && pick_found) begin
            hold_d = '0;
        end else if (state_q == GRANT && req[gnt_idx_q] && !timeout_hit) begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and next-output decision for the grant sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_idx_d   = gnt_idx_q;
        tens_d      = tens_q;
        ones_d      = ones_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    gnt_d       = N'(1) << pick_idx;
                    gnt_valid_d = 1'b1;
                    gnt_idx_d   = pick_idx;
                    tens_d      = bcd_t'(int'(pick_idx) / 10);
                    ones_d      = bcd_t'(int'(pick_idx) % 10);
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                // Only the owner's bit matters; index and digits stay latched
                // so the display keeps showing the last owner.
                if (!req[gnt_idx_q] || timeout_hit) begin
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    ptr_d       = (gnt_idx_q == OUTW'(N - 1)) ? '0
                                                              : gnt_idx_q + OUTW'(1);
                    state_d     = GAP;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, pointer and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        // NOTE: clocked blocks use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_idx_q   <= '0;
            tens_q      <= '0;
            ones_q      <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_idx_q   <= gnt_idx_d;
            tens_q      <= tens_d;
            ones_q      <= ones_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = gnt_idx_q;
    assign tens      = tens_q;
    assign ones      = ones_q;

endmodule
